router_register_param: RTL
==========================

Name: router_register_param

Overview:
Parametrised packet datapath register stage for the router. It sits between the input port and the per-destination FIFOs. The block decodes and latches the header, accumulates a selectable integrity check over header and payload, and buffers up to HOLD_DEPTH words while the destination FIFO is full. It compares the received check word, flags errors and counts them, and runs its own packet state machine so no external state decode is needed.

Parameters:
DATA_WIDTH, 8, width of every packet word
ADDR_BITS, 2, header bits [ADDR_BITS-1:0] carrying the destination
NUM_PORTS, 3, destinations 0..NUM_PORTS-1 are valid; any other value is illegal
HOLD_DEPTH, 2, depth of the hold buffer used while fifo_full (>=1)
CHECK_MODE, 0, 0 = XOR parity; 1 = additive checksum modulo 2^DATA_WIDTH
ERR_CNT_W, 8, width of the saturating error counter

Ports:
clk  in  1  clock, rising edge
rstn  in  1  asynchronous active-low reset
soft_rst  in  1  synchronous abort of the current packet
pkt_valid  in  1  high for header and payload words; low for the check word
data_in  in  DATA_WIDTH  input word
fifo_full  in  1  destination FIFO full
busy  out  1  hold buffer full; source must stall
data_out  out  DATA_WIDTH  word to the destination FIFO
data_out_valid  out  1  FIFO write strobe
dest_addr  out  ADDR_BITS  latched destination of the current packet
addr_err  out  1  one-cycle pulse: illegal header dropped
parity_done  out  1  one-cycle pulse: packet check complete
error  out  1  one-cycle pulse, coincident with parity_done, on check mismatch
err_count  out  ERR_CNT_W  saturating count of mismatched packets

Behaviour:
- Reset (rstn low, async): state IDLE; hold buffer empty. data_out, data_out_valid, dest_addr, addr_err, parity_done, error and err_count are all 0. The accumulator is 0. busy is 0.
- busy is combinational: hold_count == HOLD_DEPTH.
- A word is accepted only when the state allows it and busy=0. A word presented while busy=1 is ignored and must be held by the source.
- IDLE:
  - On pkt_valid=1 with addr = data_in[ADDR_BITS-1:0]: if addr < NUM_PORTS, latch dest_addr, set acc = data_in, route the header like a payload word, then go to LOAD.
  - If addr >= NUM_PORTS: pulse addr_err next cycle, drop the word, stay in IDLE. Subsequent pkt_valid words are dropped until pkt_valid=0 has been seen.
- LOAD, accepted word with pkt_valid=1: update the accumulator (XOR, or sum truncated to DATA_WIDTH) and route the word.
- LOAD, accepted word with pkt_valid=0: this is the check word. Store it in pkt_check, do not accumulate it, route it, then go to DRAIN.
- Routing of an accepted word, one-cycle latency:
  - fifo_full=0 and buffer empty: data_out = word, data_out_valid = 1 on the next edge.
  - fifo_full=0 and buffer non-empty: output the oldest buffered word and push the new word.
  - fifo_full=1: push the new word; data_out_valid = 0.
  - Buffer order is strict FIFO; the header is never reordered.
- When no word is accepted and fifo_full=0 with the buffer non-empty: pop one word per cycle to data_out.
- When fifo_full=1: data_out holds its value and data_out_valid = 0.
- DRAIN: pop as above. When the buffer is empty and no pop occurs, go to CHECK.
- CHECK (one cycle): pulse parity_done. If pkt_check != acc, pulse error in the same cycle and increment err_count, saturating at all-ones. Clear acc, then go to IDLE.
- Simultaneous events:
  - A push and a pop in the same cycle leave hold_count unchanged.
  - pkt_valid words arriving in DRAIN or CHECK are not accepted; the source must wait for IDLE.
- soft_rst=1 (any state, highest priority after rstn):
  - Go to IDLE, flush the buffer, clear acc, data_out_valid = 0.
  - No parity_done or error pulse.
  - err_count and dest_addr are kept.
- rstn asserted mid-packet: immediate return to reset values; the partial packet is lost.

Test Plan:
1. XOR mode, no stalls. Send header 0x05, payload 0x11, 0x22, 0x33, check word 0x05. Required: data_out_valid on 5 consecutive cycles, each one cycle after its input; dest_addr=1; parity_done pulse, error=0, err_count=0.
2. Same packet with check word 0x06. Required: parity_done and error pulse together; err_count=1. Repeat 300 times with ERR_CNT_W=8: err_count saturates at 0xFF.
3. CHECK_MODE=1, same payload. Check word 0x6B gives no error; check word 0x05 gives error.
4. fifo_full high for 4 cycles starting at payload 0x11, with HOLD_DEPTH=2. Required: 0x11 and 0x22 are buffered; busy=1; 0x33 is held by the source. After fifo_full falls, the output order is exactly 05, 11, 22, 33, check word; no loss or duplication.
5. Header 0x03 with NUM_PORTS=3. Required: addr_err pulse and no data_out_valid. The following valid packet is processed normally.
6. soft_rst asserted in the middle of payload, and separately rstn asserted in the middle of payload. Required: IDLE state, buffer empty, no parity_done. err_count is kept after soft_rst and is 0 after rstn. The next packet passes.

Source files
------------

// File: rtl/router_register_param.sv
// Packet register stage between a router input port and its per-destination FIFOs.
// Decodes the header, accumulates an integrity check, and buffers words while the FIFO is full.
module router_register_param #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_BITS  = 2,
  parameter int NUM_PORTS  = 3,
  parameter int HOLD_DEPTH = 2,
  parameter int CHECK_MODE = 0,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  soft_rst,
  input  logic                  pkt_valid,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  fifo_full,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_out_valid,
  output logic [ADDR_BITS-1:0]  dest_addr,
  output logic                  addr_err,
  output logic                  parity_done,
  output logic                  error,
  output logic [ERR_CNT_W-1:0]  err_count
);

  localparam int CNT_W = $clog2(HOLD_DEPTH + 1);
  localparam int PTR_W = (HOLD_DEPTH > 1) ? $clog2(HOLD_DEPTH) : 1;
  localparam logic [CNT_W-1:0] FULL_CNT    = CNT_W'(HOLD_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR    = PTR_W'(HOLD_DEPTH - 1);
  localparam logic [31:0]      NUM_PORTS_U = 32'(NUM_PORTS);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_CHECK = 2'd3;

  logic [1:0]            state;
  logic                  drop_pkt;
  logic [DATA_WIDTH-1:0] acc;
  logic [DATA_WIDTH-1:0] acc_next;
  logic [DATA_WIDTH-1:0] pkt_check;
  logic [DATA_WIDTH-1:0] hold_mem [HOLD_DEPTH];
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic [CNT_W-1:0]      hold_count;
  logic [ADDR_BITS-1:0]  hdr_addr;
  logic                  hdr_legal;
  logic                  accept_hdr;
  logic                  bad_hdr;
  logic                  accept_load;
  logic                  accept;
  logic                  buf_empty;
  logic                  push;
  logic                  pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign busy = (hold_count == FULL_CNT);

  // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    hdr_addr    = data_in[ADDR_BITS-1:0];
    hdr_legal   = 32'(hdr_addr) < NUM_PORTS_U;
    accept_hdr  = 1'b0;
    bad_hdr     = 1'b0;
    accept_load = 1'b0;
    if (state == S_IDLE && !drop_pkt && pkt_valid) begin
      accept_hdr = hdr_legal && !busy;
      bad_hdr    = !hdr_legal;
    end
    if (state == S_LOAD) accept_load = !busy;
    accept    = accept_hdr || accept_load;
    buf_empty = (hold_count == '0);
    // Once anything is buffered, new words queue behind it to keep strict order.
    pop       = !fifo_full && !buf_empty;
    push      = accept && (fifo_full || !buf_empty);
    acc_next  = (CHECK_MODE == 0) ? (acc ^ data_in) : (acc + data_in);
  end

  // NOTE: the hold buffer storage has no reset; hold_count guarantees no stale entry is ever read.
  always_ff @(posedge clk) begin
    if (push) hold_mem[wr_ptr] <= data_in;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state          <= S_IDLE;
      drop_pkt       <= 1'b0;
      acc            <= '0;
      pkt_check      <= '0;
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      hold_count     <= '0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
      dest_addr      <= '0;
      addr_err       <= 1'b0;
      parity_done    <= 1'b0;
      error          <= 1'b0;
      err_count      <= '0;
    end else if (soft_rst) begin
      state          <= S_IDLE;
      drop_pkt       <= 1'b0;
      acc            <= '0;
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      hold_count     <= '0;
      data_out_valid <= 1'b0;
      addr_err       <= 1'b0;
      parity_done    <= 1'b0;
      error          <= 1'b0;
    end else begin
      addr_err    <= 1'b0;
      parity_done <= 1'b0;
      error       <= 1'b0;

      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      hold_count <= hold_count + CNT_W'(1);
      else if (pop && !push) hold_count <= hold_count - CNT_W'(1);

      if (pop) begin
        data_out       <= hold_mem[rd_ptr];
        data_out_valid <= 1'b1;
      end else if (accept && !fifo_full) begin
        data_out       <= data_in;
        data_out_valid <= 1'b1;
      end else begin
        data_out_valid <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (drop_pkt && !pkt_valid) drop_pkt <= 1'b0;
          if (accept_hdr) begin
            dest_addr <= hdr_addr;
            acc       <= data_in;
            state     <= S_LOAD;
          end
          if (bad_hdr) begin
            addr_err <= 1'b1;
            drop_pkt <= 1'b1;
          end
        end
        S_LOAD: begin
          if (accept_load) begin
            if (pkt_valid) begin
              acc <= acc_next;
            end else begin
              pkt_check <= data_in;
              state     <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (buf_empty) state <= S_CHECK;
        end
        S_CHECK: begin
          parity_done <= 1'b1;
          if (pkt_check != acc) begin
            error <= 1'b1;
            if (err_count != '1) err_count <= err_count + ERR_CNT_W'(1);
          end
          acc   <= '0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
